slv_mem_mdl: RTL and testbench

//  Slave memory on the simple master/slave bus, directly downstream of the bus master stage.
//  - Single-port register-file memory with 2**ADDR_BIT_WIDTH words.
//  - Executes writes and registered reads.
//  - Flags illegal read/write collisions.
//  - Keeps saturating access statistics for bench-level checking of the master's traffic.

---
 rtl/slv_mem_mdl_pkg.sv | 23 ++
 rtl/slv_mem_mdl_if.sv | 26 ++
 rtl/slv_mem_mdl_sat_cnt.sv | 21 ++
 rtl/slv_mem_mdl.sv | 77 +++++++
 tb/tb_slv_mem_mdl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/slv_mem_mdl_pkg.sv
// rtl/slv_mem_mdl_pkg.sv - shared types and helpers for the slave memory model
package slv_mem_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WR   = 2'd2,
    ACC_COLL = 2'd3
  } acc_kind_e;

  function automatic int mem_depth(input int addr_bit_width);
    return 1 << addr_bit_width;
  endfunction

  // A collision keeps the write and drops the read, so it is its own kind.
  function automatic acc_kind_e decode_acc(input logic rd_req, input logic wr_req);
    if (rd_req && wr_req) return ACC_COLL;
    if (wr_req)           return ACC_WR;
    if (rd_req)           return ACC_RD;
    return ACC_IDLE;
  endfunction

endpackage

// File: rtl/slv_mem_mdl_if.sv
// rtl/slv_mem_mdl_if.sv - master/slave bus between the master stage and the slave memory
interface slv_mem_mdl_if #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int CNT_BIT_WIDTH  = 16
);
  logic [ADDR_BIT_WIDTH-1:0] addr;
  logic                      rd_req;
  logic                      wr_req;
  logic [DATA_BIT_WIDTH-1:0] wr_data;
  logic [DATA_BIT_WIDTH-1:0] rd_data;
  logic                      rd_vld;
  logic                      coll_err;
  logic [CNT_BIT_WIDTH-1:0]  wr_cnt;
  logic [CNT_BIT_WIDTH-1:0]  rd_cnt;

  modport master (
    output addr, rd_req, wr_req, wr_data,
    input  rd_data, rd_vld, coll_err, wr_cnt, rd_cnt
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_data,
    output rd_data, rd_vld, coll_err, wr_cnt, rd_cnt
  );
endinterface

// File: rtl/slv_mem_mdl_sat_cnt.sv
// rtl/slv_mem_mdl_sat_cnt.sv - saturating up-counter, cleared only by reset
module sat_cnt #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_sync_rst,
  input  logic                 i_incr,
  output logic [BIT_WIDTH-1:0] o_cnt
);
  logic [BIT_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      r_cnt <= '0;
    end else if (i_incr && (r_cnt != {BIT_WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/slv_mem_mdl.sv
// rtl/slv_mem_mdl.sv - single-port slave memory with registered reads,
// sticky collision flag and saturating access statistics
module slv_mem_mdl
  import slv_mem_pkg::*;
#(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int CNT_BIT_WIDTH  = 16
) (
  input  logic         i_clk,
  input  logic         i_sync_rst,
  slv_mem_mdl_if.slave bus
);
  localparam int DEPTH = mem_depth(ADDR_BIT_WIDTH);

  logic [DATA_BIT_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_BIT_WIDTH-1:0] r_rd_data;
  logic                      r_rd_vld;
  logic                      r_coll_err;
  acc_kind_e                 w_acc;
  logic                      w_wr_incr;
  logic                      w_rd_incr;
  logic [CNT_BIT_WIDTH-1:0]  w_wr_cnt;
  logic [CNT_BIT_WIDTH-1:0]  w_rd_cnt;

  assign w_acc     = decode_acc(bus.rd_req, bus.wr_req);
  assign w_wr_incr = (w_acc == ACC_WR) || (w_acc == ACC_COLL);
  assign w_rd_incr = (w_acc == ACC_RD);

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_data  <= '0;
      r_rd_vld   <= 1'b0;
      r_coll_err <= 1'b0;
    end else begin
      case (w_acc)
        ACC_WR: begin
          r_mem[bus.addr] <= bus.wr_data;
          r_rd_vld        <= 1'b0;
        end
        ACC_RD: begin
          r_rd_data <= r_mem[bus.addr];
          r_rd_vld  <= 1'b1;
        end
        ACC_COLL: begin
          r_mem[bus.addr] <= bus.wr_data;
          r_rd_vld        <= 1'b0;
          r_coll_err      <= 1'b1;
        end
        default: begin
          r_rd_vld <= 1'b0;
        end
      endcase
    end
  end

  sat_cnt #(.BIT_WIDTH(CNT_BIT_WIDTH)) u_wr_cnt (
    .i_clk      (i_clk),
    .i_sync_rst (i_sync_rst),
    .i_incr     (w_wr_incr),
    .o_cnt      (w_wr_cnt)
  );

  sat_cnt #(.BIT_WIDTH(CNT_BIT_WIDTH)) u_rd_cnt (
    .i_clk      (i_clk),
    .i_sync_rst (i_sync_rst),
    .i_incr     (w_rd_incr),
    .o_cnt      (w_rd_cnt)
  );

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_vld   = r_rd_vld;
  assign bus.coll_err = r_coll_err;
  assign bus.wr_cnt   = w_wr_cnt;
  assign bus.rd_cnt   = w_rd_cnt;
endmodule

// File: tb/tb_slv_mem_mdl.sv
// tb/tb_slv_mem_mdl.sv - directed self-checking bench for slv_mem_mdl
module tb_slv_mem_mdl;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  slv_mem_mdl_if #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8), .CNT_BIT_WIDTH(4)) bus ();

  slv_mem_mdl #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8), .CNT_BIT_WIDTH(4)) dut (
    .i_clk      (clk),
    .i_sync_rst (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] a, input logic [7:0] d);
    bus.rd_req  = rd;
    bus.wr_req  = wr;
    bus.addr    = a;
    bus.wr_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle();
    tick();
    tick();

    chk("rst_rd_data", {24'd0, bus.rd_data}, 32'h0);
    chk("rst_rd_vld", {31'd0, bus.rd_vld}, 32'h0);
    chk("rst_coll_err", {31'd0, bus.coll_err}, 32'h0);
    chk("rst_wr_cnt", {28'd0, bus.wr_cnt}, 32'h0);
    chk("rst_rd_cnt", {28'd0, bus.rd_cnt}, 32'h0);
    rst = 1'b0;

    // 1: fill and read back all four words, back to back
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'(i), 8'(8'h0A + i));
      tick();
      chk("t1_wr_no_vld", {31'd0, bus.rd_vld}, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'(i), 8'h00);
      tick();
      chk("t1_rd_vld", {31'd0, bus.rd_vld}, 32'h1);
      chk("t1_rd_data", {24'd0, bus.rd_data}, 32'(8'h0A + i));
    end
    idle();
    tick();
    chk("t1_idle_vld", {31'd0, bus.rd_vld}, 32'h0);
    chk("t1_idle_hold", {24'd0, bus.rd_data}, 32'h0D);
    chk("t1_wr_cnt", {28'd0, bus.wr_cnt}, 32'd4);
    chk("t1_rd_cnt", {28'd0, bus.rd_cnt}, 32'd4);

    // 2: read-after-write in consecutive cycles
    drive(1'b0, 1'b1, 2'd2, 8'h55);
    tick();
    drive(1'b1, 1'b0, 2'd2, 8'h00);
    tick();
    chk("t2_raw_vld", {31'd0, bus.rd_vld}, 32'h1);
    chk("t2_raw_data", {24'd0, bus.rd_data}, 32'h55);
    chk("t2_wr_cnt", {28'd0, bus.wr_cnt}, 32'd5);
    chk("t2_rd_cnt", {28'd0, bus.rd_cnt}, 32'd5);

    // 3: collision writes, drops the read, sets the sticky flag
    drive(1'b1, 1'b1, 2'd1, 8'h77);
    tick();
    chk("t3_coll_vld", {31'd0, bus.rd_vld}, 32'h0);
    chk("t3_coll_err", {31'd0, bus.coll_err}, 32'h1);
    chk("t3_coll_wr_cnt", {28'd0, bus.wr_cnt}, 32'd6);
    chk("t3_coll_rd_cnt", {28'd0, bus.rd_cnt}, 32'd5);
    idle();
    tick();
    drive(1'b1, 1'b0, 2'd1, 8'h00);
    tick();
    chk("t3_rb_vld", {31'd0, bus.rd_vld}, 32'h1);
    chk("t3_rb_data", {24'd0, bus.rd_data}, 32'h77);
    chk("t3_sticky", {31'd0, bus.coll_err}, 32'h1);

    // 4: write counter saturates at 15 (starts at 6 here)
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 2'(i), 8'(i));
      tick();
      chk("t4_wr_cnt", {28'd0, bus.wr_cnt}, (6 + i + 1 > 15) ? 32'd15 : 32'(6 + i + 1));
    end
    idle();
    tick();
    chk("t4_wr_hold", {28'd0, bus.wr_cnt}, 32'd15);
    chk("t4_rd_cnt", {28'd0, bus.rd_cnt}, 32'd6);

    // 5: reset in the middle of a read burst
    drive(1'b1, 1'b0, 2'd0, 8'h00);
    tick();
    drive(1'b1, 1'b0, 2'd1, 8'h00);
    tick();
    chk("t5_burst_vld", {31'd0, bus.rd_vld}, 32'h1);
    drive(1'b1, 1'b0, 2'd2, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("t5_rst_vld", {31'd0, bus.rd_vld}, 32'h0);
    chk("t5_rst_data", {24'd0, bus.rd_data}, 32'h0);
    chk("t5_rst_coll", {31'd0, bus.coll_err}, 32'h0);
    chk("t5_rst_wr_cnt", {28'd0, bus.wr_cnt}, 32'd0);
    chk("t5_rst_rd_cnt", {28'd0, bus.rd_cnt}, 32'd0);
    tick();
    chk("t5_post_vld", {31'd0, bus.rd_vld}, 32'h0);
    chk("t5_post_data", {24'd0, bus.rd_data}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'(i), 8'h00);
      tick();
      chk("t5_cleared_vld", {31'd0, bus.rd_vld}, 32'h1);
      chk("t5_cleared_data", {24'd0, bus.rd_data}, 32'h0);
    end

    // 6: three write/read rounds as the master stage issues them
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 1'b1, 2'(i), 8'(i));
        tick();
      end
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 1'b0, 2'(i), 8'h00);
        tick();
        chk("t6_rd_data", {24'd0, bus.rd_data}, 32'(i));
        chk("t6_rd_vld", {31'd0, bus.rd_vld}, 32'h1);
      end
    end
    idle();
    tick();
    chk("t6_coll_err", {31'd0, bus.coll_err}, 32'h0);
    chk("t6_wr_cnt", {28'd0, bus.wr_cnt}, 32'd12);
    chk("t6_rd_cnt", {28'd0, bus.rd_cnt}, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
